fifo_sched: RTL and testbench

- Scheduler in front of the 5-entry byte FIFO.
- Arbitrates two producers onto the FIFO write port using round-robin.
- Sequences bursted drains from the FIFO read port to a single valid/ready consumer.
- Uses only the FIFO's registered full/empty flags; keeps no occupancy counter of its own, because the FIFO silently drops a write equal to its newest entry.

---
 rtl/fifo_sched_if.sv | 36 +++
 rtl/fifo_sched.sv | 134 +++++++++++++
 tb/tb_fifo_sched.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_sched_if.sv
// Handshake bundle between the scheduler, its two producers, the byte FIFO and the consumer.
// The slave modport is the scheduler's view; master is the surrounding environment.
interface fifo_sched_if #(
  parameter int DWIDTH = 8
) ();
  logic              req0_valid;
  logic [DWIDTH-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [DWIDTH-1:0] req1_data;
  logic              req1_ready;
  logic [DWIDTH-1:0] fifo_wdata;
  logic              fifo_write;
  logic              fifo_read;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DWIDTH-1:0] fifo_rdata;
  logic              out_valid;
  logic [DWIDTH-1:0] out_data;
  logic              out_ready;
  logic              busy;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    input  fifo_full, fifo_empty, fifo_rdata, out_ready,
    output req0_ready, req1_ready, fifo_wdata, fifo_write, fifo_read,
    output out_valid, out_data, busy
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    output fifo_full, fifo_empty, fifo_rdata, out_ready,
    input  req0_ready, req1_ready, fifo_wdata, fifo_write, fifo_read,
    input  out_valid, out_data, busy
  );
endinterface

// File: rtl/fifo_sched.sv
// Round-robin write scheduler and burst drain sequencer in front of a 5-entry byte FIFO.
// Relies only on the FIFO's registered full/empty flags; bubble cycles absorb their lag.
module fifo_sched #(
  parameter int DWIDTH  = 8,
  parameter int BURST   = 4,
  parameter int TIMEOUT = 6,
  parameter int TW      = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  fifo_sched_if.slave bus
);

  // state | meaning
  // IDLE  | nothing pending; waits for a producer or a non-empty FIFO
  // FILL  | granting producer writes; leaves on full or idle timeout
  // DRAIN | reading bursts of up to BURST beats to the consumer
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int            BW        = $clog2(BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(BURST);
  localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT);

  state_t            state;
  state_t            state_nxt;
  logic              rr;
  logic [TW-1:0]     tmo_cnt;
  logic [BW-1:0]     burst_cnt;
  logic              wbub;
  logic              rbub;
  logic              wr_q;
  logic [DWIDTH-1:0] wdata_q;
  logic              out_valid_q;
  logic [DWIDTH-1:0] out_data_q;

  logic any_valid;
  logic both_valid;
  logic grant;
  logic sel1;
  logic tmo_hit;
  logic rd;
  logic burst_done;
  logic drain_dry;

  always_comb begin
    any_valid  = bus.req0_valid | bus.req1_valid;
    both_valid = bus.req0_valid & bus.req1_valid;
    grant      = (state != DRAIN) && !bus.fifo_full && !wbub && any_valid;
    sel1       = bus.req1_valid && (!bus.req0_valid || rr);
    // A write accepted in the terminal-count cycle restarts the idle window.
    tmo_hit    = (tmo_cnt == TMO_MAX) && !grant;
    burst_done = (burst_cnt == BURST_MAX);
    rd         = (state == DRAIN) && !bus.fifo_empty && !out_valid_q && !rbub && !burst_done;
    drain_dry  = bus.fifo_empty && !rbub && !out_valid_q;

    state_nxt = state;
    case (state)
      IDLE: begin
        if (any_valid)
          state_nxt = FILL;
        else if (!bus.fifo_empty)
          state_nxt = DRAIN;
      end
      FILL: begin
        if (bus.fifo_full)
          state_nxt = DRAIN;
        else if (tmo_hit)
          state_nxt = bus.fifo_empty ? IDLE : DRAIN;
      end
      DRAIN: begin
        if (burst_done || drain_dry)
          state_nxt = FILL;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr          <= 1'b0;
      tmo_cnt     <= '0;
      burst_cnt   <= '0;
      wbub        <= 1'b0;
      rbub        <= 1'b0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state <= state_nxt;
      wbub  <= grant;
      wr_q  <= grant;
      rbub  <= rd;

      if (grant) begin
        wdata_q <= sel1 ? bus.req1_data : bus.req0_data;
        if (both_valid)
          rr <= ~rr;
      end

      if (rd) begin
        out_valid_q <= 1'b1;
        out_data_q  <= bus.fifo_rdata;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      if ((state_nxt == DRAIN) && (state != DRAIN))
        burst_cnt <= '0;
      else if (rd)
        burst_cnt <= burst_cnt + BW'(1);

      if ((state_nxt != state) || grant)
        tmo_cnt <= '0;
      else if ((state == FILL) && (tmo_cnt != TMO_MAX))
        tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  assign bus.req0_ready = grant && !sel1;
  assign bus.req1_ready = grant && sel1;
  assign bus.fifo_write = wr_q;
  assign bus.fifo_wdata = wdata_q;
  assign bus.fifo_read  = rd;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_fifo_sched.sv
// Bench for fifo_sched: behavioural 5-entry FIFO (registered flags, drops a write equal to
// its newest entry), per-cycle vector tables, and a producer-to-consumer scoreboard.
module tb_fifo_sched;

  logic clk;
  logic rst_n;

  fifo_sched_if #(.DWIDTH(8)) bus ();

  fifo_sched #(.DWIDTH(8), .BURST(4), .TIMEOUT(6), .TW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [0:4];
  int         wp, rp, cnt, fm_c;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp             <= 0;
      rp             <= 0;
      cnt            <= 0;
      bus.fifo_full  <= 1'b0;
      bus.fifo_empty <= 1'b1;
    end else begin
      fm_c = cnt;
      if (bus.fifo_write && (cnt < 5) && !((cnt > 0) && (bus.fifo_wdata == mem[(wp + 4) % 5]))) begin
        mem[wp] <= bus.fifo_wdata;
        wp      <= (wp + 1) % 5;
        fm_c    = fm_c + 1;
      end
      if (bus.fifo_read && (cnt > 0)) begin
        rp   <= (rp + 1) % 5;
        fm_c = fm_c - 1;
      end
      cnt            <= fm_c;
      bus.fifo_full  <= (fm_c == 5);
      bus.fifo_empty <= (fm_c == 0);
    end
  end

  assign bus.fifo_rdata = mem[rp];

  typedef struct {
    logic       v0;
    logic       v1;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       r0;
    logic       r1;
    logic       fw;
    logic [7:0] wd;
  } vec_t;

  vec_t       arb_vec [12];
  vec_t       sr_vec  [8];
  logic [7:0] sb [$];
  int         errors;
  int         checks;
  logic       prev_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v, input int idx);
    bus.req0_valid = v.v0;
    bus.req1_valid = v.v1;
    bus.req0_data  = v.d0;
    bus.req1_data  = v.d1;
    @(negedge clk);
    chk($sformatf("vec%0d_req0_ready", idx), bus.req0_ready, v.r0);
    chk($sformatf("vec%0d_req1_ready", idx), bus.req1_ready, v.r1);
    chk($sformatf("vec%0d_fifo_write", idx), bus.fifo_write, v.fw);
    if (v.fw)
      chk($sformatf("vec%0d_fifo_wdata", idx), bus.fifo_wdata, v.wd);
    step();
  endtask

  task automatic send0(input logic [7:0] d, input string name);
    bit ok;
    ok = 1'b0;
    bus.req0_data  = d;
    bus.req0_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.req0_ready) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk(name, ok, 1'b1);
    if (ok)
      step();
  endtask

  task automatic wait_idle(input int limit, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk(name, ok, 1'b1);
    step();
  endtask

  task automatic wait_read(input int limit, input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (bus.fifo_full)
        chk("full_no_grant", bus.req0_ready, 1'b0);
      if (bus.fifo_read) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk(name, ok, 1'b1);
  endtask

  initial begin
    bit ok;
    int n;
    logic [7:0] exp_b;

    arb_vec[0]  = '{1'b1, 1'b1, 8'h10, 8'h20, 1'b1, 1'b0, 1'b0, 8'h00};
    arb_vec[1]  = '{1'b1, 1'b1, 8'h10, 8'h20, 1'b0, 1'b0, 1'b1, 8'h10};
    arb_vec[2]  = '{1'b1, 1'b1, 8'h10, 8'h20, 1'b0, 1'b1, 1'b0, 8'h00};
    arb_vec[3]  = '{1'b1, 1'b1, 8'h10, 8'h20, 1'b0, 1'b0, 1'b1, 8'h20};
    arb_vec[4]  = '{1'b1, 1'b1, 8'h10, 8'h20, 1'b1, 1'b0, 1'b0, 8'h00};
    arb_vec[5]  = '{1'b1, 1'b1, 8'h10, 8'h20, 1'b0, 1'b0, 1'b1, 8'h10};
    arb_vec[6]  = '{1'b1, 1'b1, 8'h10, 8'h20, 1'b0, 1'b1, 1'b0, 8'h00};
    arb_vec[7]  = '{1'b1, 1'b1, 8'h10, 8'h20, 1'b0, 1'b0, 1'b1, 8'h20};
    arb_vec[8]  = '{1'b1, 1'b1, 8'h10, 8'h20, 1'b1, 1'b0, 1'b0, 8'h00};
    arb_vec[9]  = '{1'b1, 1'b1, 8'h10, 8'h20, 1'b0, 1'b0, 1'b1, 8'h10};
    arb_vec[10] = '{1'b1, 1'b1, 8'h10, 8'h20, 1'b0, 1'b0, 1'b0, 8'h00};
    arb_vec[11] = '{1'b1, 1'b1, 8'h10, 8'h20, 1'b0, 1'b0, 1'b0, 8'h00};

    sr_vec[0] = '{1'b0, 1'b1, 8'h00, 8'hA1, 1'b0, 1'b1, 1'b0, 8'h00};
    sr_vec[1] = '{1'b0, 1'b1, 8'h00, 8'hA2, 1'b0, 1'b0, 1'b1, 8'hA1};
    sr_vec[2] = '{1'b0, 1'b1, 8'h00, 8'hA2, 1'b0, 1'b1, 1'b0, 8'h00};
    sr_vec[3] = '{1'b0, 1'b1, 8'h00, 8'hA3, 1'b0, 1'b0, 1'b1, 8'hA2};
    sr_vec[4] = '{1'b1, 1'b1, 8'hB1, 8'hA3, 1'b1, 1'b0, 1'b0, 8'h00};
    sr_vec[5] = '{1'b1, 1'b1, 8'hB2, 8'hA3, 1'b0, 1'b0, 1'b1, 8'hB1};
    sr_vec[6] = '{1'b1, 1'b1, 8'hB2, 8'hA3, 1'b0, 1'b1, 1'b0, 8'h00};
    sr_vec[7] = '{1'b0, 1'b0, 8'hB2, 8'hA3, 1'b0, 1'b0, 1'b1, 8'hA3};

    errors         = 0;
    checks         = 0;
    prev_rd        = 1'b0;
    rst_n          = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_data  = 8'h00;
    bus.req1_data  = 8'h00;
    bus.out_ready  = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (bus.req0_valid && bus.req0_ready) sb.push_back(bus.req0_data);
          if (bus.req1_valid && bus.req1_ready) sb.push_back(bus.req1_data);
          if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
              chk("sb_underflow", 1'b1, 1'b0);
            end else begin
              exp_b = sb.pop_front();
              chk("out_data", bus.out_data, exp_b);
            end
          end
          if (bus.fifo_read) begin
            chk("read_spacing", prev_rd, 1'b0);
            chk("rw_exclusive", bus.fifo_write, 1'b0);
          end
          prev_rd = bus.fifo_read;
        end else begin
          prev_rd = 1'b0;
        end
      end
      begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog");
      end
    join_none

    #13;
    chk("rst_fifo_write", bus.fifo_write, 1'b0);
    chk("rst_fifo_read",  bus.fifo_read,  1'b0);
    chk("rst_out_valid",  bus.out_valid,  1'b0);
    chk("rst_out_data",   bus.out_data,   8'h00);
    chk("rst_busy",       bus.busy,       1'b0);
    chk("rst_ready",      {bus.req0_ready, bus.req1_ready}, 2'b00);
    step();
    rst_n = 1'b1;

    // Arbitration: both producers valid until the FIFO fills.
    for (int i = 0; i < 12; i++)
      apply(arb_vec[i], i);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    wait_idle(100, "arb_idle");

    // Full trigger: five beats from req0, then a pending sixth beat.
    for (int k = 1; k <= 5; k++)
      send0(8'(k), $sformatf("full_send%0d", k));
    bus.req0_data  = 8'h06;
    bus.req0_valid = 1'b1;
    wait_read(40, "full_first_read", ok);
    n = ok ? 1 : 0;
    for (int i = 1; i < 12; i++) begin
      step();
      if (bus.req0_valid && !bus.req0_ready && sb.size() > 0 && sb[sb.size() - 1] == 8'h06)
        bus.req0_valid = 1'b0;
      @(negedge clk);
      if (bus.fifo_read) n++;
    end
    chk("burst_len", n, 4);
    step();
    if (bus.req0_valid && !(sb.size() > 0 && sb[sb.size() - 1] == 8'h06))
      send0(8'h06, "full_send6");
    bus.req0_valid = 1'b0;
    wait_idle(100, "full_idle");

    // Timeout: two beats then silence.
    send0(8'h33, "tmo_send33");
    send0(8'h44, "tmo_send44");
    bus.req0_valid = 1'b0;
    n = 1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.fifo_read) begin
        ok = 1'b1;
        break;
      end
      step();
      n++;
    end
    chk("tmo_read_seen", ok, 1'b1);
    chk("tmo_delay", n, 8);
    n = 0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      n++;
      @(negedge clk);
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("tmo_idle_seen", ok, 1'b1);
    chk("tmo_idle_delay", n, 12);
    step();

    // Backpressure: consumer stalls with a beat held, then reset strikes mid-DRAIN.
    bus.out_ready = 1'b0;
    send0(8'h55, "bp_send55");
    send0(8'h66, "bp_send66");
    bus.req0_valid = 1'b0;
    wait_read(40, "bp_first_read", ok);
    step();
    bus.req0_data  = 8'h77;
    bus.req0_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid",  bus.out_valid,  1'b1);
      chk("bp_out_data",   bus.out_data,   8'h55);
      chk("bp_req0_ready", bus.req0_ready, 1'b0);
      chk("bp_single_read", bus.fifo_read, 1'b0);
      if (i < 9) step();
    end
    #1;
    bus.req0_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid",  bus.out_valid,  1'b0);
    chk("arst_fifo_read",  bus.fifo_read,  1'b0);
    chk("arst_fifo_write", bus.fifo_write, 1'b0);
    chk("arst_busy",       bus.busy,       1'b0);
    sb.delete();
    bus.out_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;

    // Single requester, then both: pointer must still favour req0.
    for (int i = 0; i < 8; i++)
      apply(sr_vec[i], 100 + i);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    wait_idle(100, "sr_idle");

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
